// File: rtl/dpath_pkg.sv
// dpath_pkg
// Shared types for the R -> W data stage of the copy engine.
//   axi_resp_t : AXI response encoding seen on the R channel.
//   state_t    : run state of rd_wr_dpath (IDLE, RUN, DRAIN).
package dpath_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/rd_wr_dpath_sync_fifo.sv
// sync_fifo
// Small synchronous FIFO with registered storage and a synchronous flush.
// Pointers carry one extra wrap bit so full and empty can be told apart.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : return both pointers to 0 (contents become invalid)
//   i_push     : write i_data at the tail (ignored when full)
//   i_data     : write data
//   i_pop      : drop the head entry (ignored when empty)
//   o_data     : current head entry
//   o_full     : no free entry
//   o_empty    : no valid entry
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // Next pointers and storage; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = i_data;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/rd_wr_dpath.sv
// rd_wr_dpath
// Data stage of the copy engine: takes 2**CNT_WIDTH beats from the AXI-Lite R
// channel, buffers them in a small FIFO and presents them on W in order.
// Optional feature macro: RD_WR_DPATH_BSWAP_EN byte-reverses each beat on push.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_start        : pulse, begins a new run (flushes and clears everything)
//   o_done         : last W beat of the run accepted; holds until i_start
//   o_err          : sticky, some R beat of this run had a non-OKAY response
//   i_rd_data_vld, i_rd_data, i_rd_resp, o_rd_data_rdy : R channel
//   o_wr_data_vld, o_wr_data, o_wr_strb, i_wr_data_rdy : W channel
module rd_wr_dpath
  import dpath_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  output logic                    o_done,
  output logic                    o_err,
  input  logic                    i_rd_data_vld,
  input  logic [DATA_WIDTH-1:0]   i_rd_data,
  input  logic [1:0]              i_rd_resp,
  output logic                    o_rd_data_rdy,
  output logic                    o_wr_data_vld,
  output logic [DATA_WIDTH-1:0]   o_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_wr_strb,
  input  logic                    i_wr_data_rdy
);

  localparam int NB = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  rd_fire;
  logic                  wr_fire;

  assign o_rd_data_rdy = (state_q == RUN) && !fifo_full;
  assign o_wr_data_vld = !fifo_empty;
  assign o_wr_data     = fifo_head;
  // Strobes are all ones whenever a beat is offered, and zero out of reset.
  assign o_wr_strb     = {NB{o_wr_data_vld}};
  assign o_done        = done_q;
  assign o_err         = err_q;

  assign rd_fire = i_rd_data_vld && o_rd_data_rdy;
  assign wr_fire = o_wr_data_vld && i_wr_data_rdy;

`ifdef RD_WR_DPATH_BSWAP_EN
  // Byte i of the R beat lands in byte NB-1-i of the FIFO entry.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < NB; i++) begin
      push_data[(NB-1-i)*8 +: 8] = i_rd_data[i*8 +: 8];
    end
  end
`else
  assign push_data = i_rd_data;
`endif

  // Handshakes coinciding with i_start are dropped: the flush takes priority.
  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_start),
    .i_push  (rd_fire && !i_start),
    .i_data  (push_data),
    .i_pop   (wr_fire && !i_start),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Run sequencing: reads stop after the last counted R beat (RUN -> DRAIN);
  // the run completes when the last counted W beat leaves (DRAIN -> IDLE).
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    done_d   = done_q;
    err_d    = err_q;
    if (i_start) begin
      state_d  = RUN;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      if (rd_fire) begin
        rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
        if (axi_resp_t'(i_rd_resp) != OKAY) begin
          err_d = 1'b1;
        end
        if (&rd_cnt_q) begin
          state_d = DRAIN;
        end
      end
      if (wr_fire) begin
        wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
        if ((state_q == DRAIN) && (&wr_cnt_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_rd_wr_dpath.sv
// tb_rd_wr_dpath
// Randomised bench for rd_wr_dpath with a queue-based reference model.
// Stimulus is driven 1 time unit after each rising edge; a monitor on the
// falling edge compares the DUT against the model and then advances the model
// by the handshakes that the coming rising edge will complete.
module tb_rd_wr_dpath;

  localparam int DW    = 32;
  localparam int CW    = 2;
  localparam int FD    = 4;
  localparam int NB    = DW / 8;
  localparam int BEATS = 1 << CW;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic          o_done;
  logic          o_err;
  logic          i_rd_data_vld;
  logic [DW-1:0] i_rd_data;
  logic [1:0]    i_rd_resp;
  logic          o_rd_data_rdy;
  logic          o_wr_data_vld;
  logic [DW-1:0] o_wr_data;
  logic [NB-1:0] o_wr_strb;
  logic          i_wr_data_rdy;

  rd_wr_dpath #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .o_done        (o_done),
    .o_err         (o_err),
    .i_rd_data_vld (i_rd_data_vld),
    .i_rd_data     (i_rd_data),
    .i_rd_resp     (i_rd_resp),
    .o_rd_data_rdy (o_rd_data_rdy),
    .o_wr_data_vld (o_wr_data_vld),
    .o_wr_data     (o_wr_data),
    .o_wr_strb     (o_wr_strb),
    .i_wr_data_rdy (i_wr_data_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: beats in flight, run flags and beat counts.
  logic [DW-1:0] exp_q[$];
  bit            m_active = 0;
  bit            m_done   = 0;
  bit            m_err    = 0;
  int            m_rd_cnt = 0;
  int            m_wr_cnt = 0;

  function automatic logic [DW-1:0] expWord(input logic [DW-1:0] d);
`ifdef RD_WR_DPATH_BSWAP_EN
    logic [DW-1:0] r;
    r = {<<8{d}};
    return r;
`else
    return d;
`endif
  endfunction

  function automatic logic [1:0] randResp();
    if ($urandom_range(0, 3) == 0) return 2'($urandom_range(0, 3));
    return 2'b00;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit rvld, input logic [DW-1:0] rdata,
                               input logic [1:0] rresp, input bit wrdy);
    i_start       = start;
    i_rd_data_vld = rvld;
    i_rd_data     = rdata;
    i_rd_resp     = rresp;
    i_wr_data_rdy = wrdy;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    exp_q.delete();
    m_active = 0;
    m_done   = 0;
    m_err    = 0;
    m_rd_cnt = 0;
    m_wr_cnt = 0;
  endtask

  // Keep feeding random traffic until the model says the run is complete.
  task automatic runToDone(input string name, input bit randWrRdy);
    int n = 0;
    while (!m_done && n < 400) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), $urandom, randResp(),
                    randWrRdy ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    vectors++;
    if (!m_done) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: run not complete after %0d cycles", name, n);
    end
    applyStimulus(0, 0, '0, 2'b00, 1);
  endtask

  // Monitor: compare against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("rd_rdy", DW'(o_rd_data_rdy), DW'(m_active && exp_q.size() < FD));
      checkOutput("wr_vld", DW'(o_wr_data_vld), DW'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        checkOutput("wr_data", o_wr_data, exp_q[0]);
        checkOutput("wr_strb", DW'(o_wr_strb), DW'({NB{1'b1}}));
      end
      checkOutput("done", DW'(o_done), DW'(m_done));
      checkOutput("err", DW'(o_err), DW'(m_err));
      if (i_start) begin
        modelReset();
        m_active = 1;
      end else begin
        if (o_wr_data_vld && i_wr_data_rdy && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          m_wr_cnt++;
          if (m_wr_cnt == BEATS) m_done = 1;
        end
        if (i_rd_data_vld && o_rd_data_rdy) begin
          exp_q.push_back(expWord(i_rd_data));
          if (i_rd_resp != 2'b00) m_err = 1;
          m_rd_cnt++;
          if (m_rd_cnt == BEATS) m_active = 0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_start = 0; i_rd_data_vld = 0; i_rd_data = '0; i_rd_resp = 2'b00; i_wr_data_rdy = 0;
    #12;
    checkOutput("reset_rd_rdy", DW'(o_rd_data_rdy), '0);
    checkOutput("reset_wr_vld", DW'(o_wr_data_vld), '0);
    checkOutput("reset_wr_data", o_wr_data, '0);
    checkOutput("reset_done", DW'(o_done), '0);
    checkOutput("reset_err", DW'(o_err), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(0, 1, $urandom, 2'b00, 1);

    // Basic copy: four back-to-back beats, W always ready.
    applyStimulus(1, 0, '0, 2'b00, 1);
    for (int i = 0; i < BEATS; i++) applyStimulus(0, 1, DW'(32'h11 * (i + 1)), 2'b00, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, '0, 2'b00, 1);
    checkOutput("basic_done", DW'(o_done), 1);
    checkOutput("basic_err", DW'(o_err), 0);

    // Backpressure: W stalled for 10 cycles while R is always offered.
    applyStimulus(1, 0, '0, 2'b00, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, $urandom, 2'b00, 0);
    checkOutput("bp_rd_rdy", DW'(o_rd_data_rdy), 0);
    runToDone("bp", 0);

    // Error on the second beat.
    applyStimulus(1, 0, '0, 2'b00, 1);
    applyStimulus(0, 1, $urandom, 2'b00, 1);
    applyStimulus(0, 1, $urandom, 2'b10, 1);
    runToDone("err", 1);
    checkOutput("err_sticky", DW'(o_err), 1);

    // Restart mid-run with one beat buffered; handshakes with i_start are dropped.
    applyStimulus(1, 0, '0, 2'b00, 0);
    applyStimulus(0, 1, $urandom, 2'b00, 0);
    applyStimulus(0, 1, $urandom, 2'b00, 1);
    applyStimulus(1, 1, $urandom, 2'b00, 1);
    checkOutput("restart_wr_vld", DW'(o_wr_data_vld), 0);
    runToDone("restart", 1);

    // Byte-order check with a recognisable pattern.
    applyStimulus(1, 0, '0, 2'b00, 1);
    applyStimulus(0, 1, 32'h11223344, 2'b00, 0);
`ifdef RD_WR_DPATH_BSWAP_EN
    checkOutput("swap_data", o_wr_data, 32'h44332211);
`else
    checkOutput("swap_data", o_wr_data, 32'h11223344);
`endif
    runToDone("swap", 1);

    // Fully random runs.
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), $urandom, randResp(), 1'($urandom_range(0, 1)));
      runToDone("random", 1);
    end

    // Asynchronous reset in the middle of a run.
    applyStimulus(1, 0, '0, 2'b00, 0);
    applyStimulus(0, 1, $urandom, 2'b10, 0);
    applyStimulus(0, 1, $urandom, 2'b00, 0);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("arst_rd_rdy", DW'(o_rd_data_rdy), '0);
    checkOutput("arst_wr_vld", DW'(o_wr_data_vld), '0);
    checkOutput("arst_wr_data", o_wr_data, '0);
    checkOutput("arst_wr_strb", DW'(o_wr_strb), '0);
    checkOutput("arst_done", DW'(o_done), '0);
    checkOutput("arst_err", DW'(o_err), '0);
    applyStimulus(0, 1, $urandom, 2'b00, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, $urandom, 2'b00, 1);
    checkOutput("arst_idle_rdy", DW'(o_rd_data_rdy), '0);
    applyStimulus(1, 1, $urandom, 2'b00, 1);
    runToDone("after_reset", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
